// File: rtl/random_range_gen_if.sv
`timescale 1ns/1ps
// Draw-request bus for random_range_gen: request/seed controls in, result/status out.
interface random_range_gen_if #(
    parameter int WIDTH = 4
);
    logic             rise;
    logic             seed_load;
    logic [15:0]      seed_val;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;

    // Requester side (game controller / testbench)
    modport master (
        output rise, seed_load, seed_val,
        input  dout, valid, busy
    );

    // Generator side
    modport slave (
        input  rise, seed_load, seed_val,
        output dout, valid, busy
    );
endinterface

// File: rtl/random_range_gen.sv
`timescale 1ns/1ps
// random_range_gen: free-running 16-bit Galois LFSR with a request-driven
// rejection-sampling draw into [MIN_VAL, MAX_VAL], optional no-immediate-repeat,
// and a bounded-retry fallback so every draw completes within MAX_TRIES cycles.
module random_range_gen #(
    parameter int          WIDTH     = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MIN_VAL   = 0,
    parameter int          MAX_VAL   = 3,
    parameter int          NO_REPEAT = 0,
    parameter int          MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              resetN,
    random_range_gen_if.slave rng_if
);

    localparam int RANGE = MAX_VAL - MIN_VAL;
    // Smallest all-ones mask covering RANGE; keeps rejection rate below one half.
    localparam int MASK  = (1 << $clog2(RANGE + 1)) - 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [WIDTH-1:0] MASK_W   = WIDTH'(MASK);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH:0]   MIN_X    = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   RANGE_X  = (WIDTH+1)'(RANGE);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [15:0]      TAPS     = 16'hB400;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             rise_q;
    logic             rise_edge;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             have_last_q, have_last_d;

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] fallback;
    logic [WIDTH:0]   cand_x, val_x, dout_x;
    logic             in_range, repeat_hit, accept, last_try;

    // Seed reload wins over the normal shift; a zero seed would lock the LFSR, so it maps to SEED.
    assign lfsr_d = rng_if.seed_load ? ((rng_if.seed_val == 16'h0000) ? SEED : rng_if.seed_val)
                                     : ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000));

    assign rise_edge = rng_if.rise & ~rise_q;

    // Candidate evaluation; all comparisons are done one bit wider so MIN_VAL+cand cannot wrap.
    assign cand       = lfsr_q[WIDTH-1:0] & MASK_W;
    assign cand_x     = {1'b0, cand};
    assign val_x      = MIN_X + cand_x;
    assign dout_x     = {1'b0, dout_q};
    assign in_range   = (cand_x <= RANGE_X);
    assign repeat_hit = (NO_REPEAT != 0) && (RANGE > 0) && have_last_q && (val_x == dout_x);
    assign accept     = in_range && !repeat_hit;
    assign last_try   = (tries_q == LAST_TRY);
    // Step past the previous value (wrapping to MIN_VAL); in range and distinct whenever RANGE>0.
    assign fallback   = (have_last_q && (dout_x < MAX_X)) ? (dout_q + WIDTH'(1)) : MIN_W;

    // LFSR advances every clock
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Previous-cycle copy of rise for edge detection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= rng_if.rise;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: edges arriving while a draw is running are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rise_edge) state_d = DRAW;
            DRAW: if (accept || last_try) state_d = IDLE;
        endcase
    end

    // FSM outputs: result, strobe, retry count and repeat-history next values
    always_comb begin
        tries_d     = tries_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        have_last_d = have_last_q;
        case (state_q)
            IDLE: begin
                if (rise_edge) tries_d = '0;
            end
            DRAW: begin
                if (accept) begin
                    dout_d      = val_x[WIDTH-1:0];
                    valid_d     = 1'b1;
                    have_last_d = 1'b1;
                end else if (last_try) begin
                    dout_d      = fallback;
                    valid_d     = 1'b1;
                    have_last_d = 1'b1;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
        endcase
    end

    // Result and bookkeeping registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tries_q     <= '0;
            dout_q      <= MIN_W;
            valid_q     <= 1'b0;
            have_last_q <= 1'b0;
        end else begin
            tries_q     <= tries_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            have_last_q <= have_last_d;
        end
    end

    assign rng_if.dout  = dout_q;
    assign rng_if.valid = valid_q;
    assign rng_if.busy  = (state_q == DRAW);

endmodule
